// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and small helper functions for the AES-128
// key schedule and the cipher datapath that reuses its S-box.
package aes_pkg;

   localparam int         AES128_NUM_ROUNDS = 10;
   localparam logic [7:0] RCON_INIT         = 8'h8d;
   localparam logic [7:0] RCON_POLY         = 8'h1b;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_GEN  = 1'b1
   } key_state_e;

   function automatic logic [31:0] rotword(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // xtime in GF(2^8): the seed 8'h8d steps to 8'h01 on the first update.
   function automatic logic [7:0] rcon_step(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (RCON_POLY & {8{r[7]}});
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Four parallel AES forward S-boxes applied bytewise to a 32-bit word (SubWord).
module aes_sbox (
   input  logic [31:0] word,
   output logic [31:0] subst
);

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   always_comb begin
      subst = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};
   end

endmodule

// File: rtl/aes_key_expand128.sv
// AES-128 key schedule: expands the cipher key into round keys 0..NUM_ROUNDS,
// one per cycle, and serves them from a registered read port.
module aes_key_expand128 #(
   parameter int         NUM_ROUNDS = aes_pkg::AES128_NUM_ROUNDS,
   parameter logic [7:0] RCON_INIT  = aes_pkg::RCON_INIT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         init,
   input  logic [127:0] key,
   input  logic [3:0]   round,
   output logic [127:0] round_key,
   output logic         ready
);

   import aes_pkg::*;

   localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

   key_state_e   state_q;
   key_state_e   state_d;
   logic         load_key;
   logic         gen_step;
   logic         last_round;

   logic [7:0]   rcon_reg;
   logic [7:0]   rcon_new;
   logic [3:0]   rnd_ctr;
   logic [127:0] prev_key;
   logic [127:0] next_key;
   logic [127:0] key_mem [0:NUM_ROUNDS];

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  sub_word;
   logic [31:0]  t_word;
   logic [31:0]  n0, n1, n2, n3;

   assign last_round = (rnd_ctr == LAST_RND);

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // A fresh init always restarts expansion, even mid-generation.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (init) state_d = ST_GEN;
         ST_GEN: begin
            if (init)            state_d = ST_GEN;
            else if (last_round) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      load_key = init;
      gen_step = (state_q == ST_GEN) && !init;
   end

   aes_sbox u_sbox (
      .word  (rotword(w3)),
      .subst (sub_word)
   );

   always_comb begin
      rcon_new = rcon_step(rcon_reg);
      {w0, w1, w2, w3} = prev_key;
      t_word   = sub_word ^ {rcon_new, 24'h0};
      n0       = w0 ^ t_word;
      n1       = w1 ^ n0;
      n2       = w2 ^ n1;
      n3       = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rcon_reg <= 8'h00;
         rnd_ctr  <= 4'd0;
         prev_key <= 128'h0;
         ready    <= 1'b0;
         for (int i = 0; i <= NUM_ROUNDS; i++) key_mem[i] <= 128'h0;
      end else if (load_key) begin
         key_mem[0] <= key;
         prev_key   <= key;
         rcon_reg   <= RCON_INIT;
         rnd_ctr    <= 4'd1;
         ready      <= 1'b0;
      end else if (gen_step) begin
         key_mem[rnd_ctr] <= next_key;
         prev_key         <= next_key;
         rcon_reg         <= rcon_new;
         rnd_ctr          <= rnd_ctr + 4'd1;
         if (last_round) ready <= 1'b1;
      end
   end

   // Reads are not gated by ready; partially expanded contents are visible.
   always_ff @(posedge clk) begin
      if (reset)                  round_key <= 128'h0;
      else if (round <= LAST_RND) round_key <= key_mem[round];
      else                        round_key <= 128'h0;
   end

endmodule

// File: tb/tb_aes_key_expand128.sv
// Directed bench for the AES-128 key schedule against FIPS-197 reference vectors.
module tb_aes_key_expand128;

   logic         clk;
   logic         reset;
   logic         init;
   logic [127:0] key;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic         ready;

   int compared = 0;
   int mismatched = 0;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_A    = 128'h000102030405060708090a0b0c0d0e0f;

   logic [127:0] fips_rk [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   logic [7:0] rcon_seq [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   aes_key_expand128 dut (
      .clk       (clk),
      .reset     (reset),
      .init      (init),
      .key       (key),
      .round     (round),
      .round_key (round_key),
      .ready     (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Pulse init for exactly one edge with the given key.
   task automatic applyStimulus(input logic [127:0] k);
      key  = k;
      init = 1'b1;
      tick();
      init = 1'b0;
   endtask

   task automatic waitReady(input string tag);
      int cycles = 0;
      while (!ready && cycles < 20) begin
         tick();
         cycles++;
      end
      checkOutput({tag, "_latency"}, 128'(cycles), 128'd10);
   endtask

   task automatic readRound(input logic [3:0] r, input string tag,
                            input logic [127:0] expected);
      round = r;
      tick();
      checkOutput($sformatf("%s_r%0d", tag, r), round_key, expected);
   endtask

   initial begin
      reset = 1'b1;
      init  = 1'b0;
      key   = '0;
      round = 4'd0;
      repeat (2) tick();
      checkOutput("reset_ready", 128'(ready), 128'd0);
      checkOutput("reset_rk", round_key, 128'h0);
      reset = 1'b0;
      tick();

      $display("[TB] FIPS key expansion");
      applyStimulus(FIPS_KEY);
      checkOutput("fips_ready_low", 128'(ready), 128'd0);
      waitReady("fips");
      for (int r = 0; r <= 10; r++) readRound(4'(r), "fips", fips_rk[r]);

      $display("[TB] out-of-range reads and read latency");
      readRound(4'd11, "oob", 128'h0);
      readRound(4'd15, "oob", 128'h0);
      readRound(4'd0, "lat", FIPS_KEY);
      round = 4'd10;
      #2;
      checkOutput("lat_hold", round_key, FIPS_KEY);
      tick();
      checkOutput("lat_update", round_key, fips_rk[10]);

      key = KEY_A;
      repeat (2) tick();
      readRound(4'd0, "key_ignored", FIPS_KEY);

      $display("[TB] zero key, re-init while ready");
      applyStimulus(128'h0);
      checkOutput("reinit_ready_drop", 128'(ready), 128'd0);
      waitReady("zero");
      readRound(4'd0, "zero", 128'h0);
      readRound(4'd1, "zero", 128'h62636363626363636263636362636363);
      readRound(4'd10, "zero", 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      $display("[TB] rcon sequence");
      applyStimulus(FIPS_KEY);
      for (int i = 1; i <= 10; i++) begin
         tick();
         checkOutput($sformatf("rcon_e%0d", i), 128'(dut.rcon_reg), 128'(rcon_seq[i]));
      end
      checkOutput("rcon_ready", 128'(ready), 128'd1);

      $display("[TB] abort mid-generation");
      applyStimulus(KEY_A);
      repeat (4) tick();
      applyStimulus(FIPS_KEY);
      checkOutput("abort_ready_low", 128'(ready), 128'd0);
      waitReady("abort");
      for (int r = 0; r <= 10; r++) readRound(4'(r), "abort", fips_rk[r]);

      $display("[TB] reset mid-generation");
      applyStimulus(KEY_A);
      repeat (5) tick();
      reset = 1'b1;
      tick();
      checkOutput("midreset_ready", 128'(ready), 128'd0);
      checkOutput("midreset_rk", round_key, 128'h0);
      reset = 1'b0;
      for (int r = 0; r <= 10; r++) readRound(4'(r), "cleared", 128'h0);

      reset = 1'b1;
      applyStimulus(FIPS_KEY);
      reset = 1'b0;
      repeat (12) tick();
      checkOutput("reset_init_ready", 128'(ready), 128'd0);
      readRound(4'd0, "reset_init", 128'h0);
      readRound(4'd1, "reset_init", 128'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
